// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to freeze in TRAP on an illegal instruction.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        br_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_src_a,
    output logic [2:0]  imm_type,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        mdr_we,
    output logic        retire,
    output logic        illegal
);

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t state_q, state_d;

    logic [4:0] opc;
    logic       quad_ok;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic       legal;
    logic       unused_inst;

    assign opc         = inst[6:2];
    assign quad_ok     = (inst[1:0] == 2'b11);
    assign unused_inst = ^inst[31:7];

    assign is_r     = quad_ok && (opc == OP_R);
    assign is_i     = quad_ok && (opc == OP_I);
    assign is_ld    = quad_ok && (opc == OP_LOAD);
    assign is_st    = quad_ok && (opc == OP_STORE);
    assign is_br    = quad_ok && (opc == OP_BRANCH);
    assign is_jal   = quad_ok && (opc == OP_JAL);
    assign is_jalr  = quad_ok && (opc == OP_JALR);
    assign is_lui   = quad_ok && (opc == OP_LUI);
    assign is_auipc = quad_ok && (opc == OP_AUIPC);
    assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;

    // Immediate format follows the IR at all times, but is held at 0 in BOOT so reset is fully quiet.
    always_comb begin
        imm_type = IMM_I;
        if (state_q != S_BOOT) begin
            if (is_st)                 imm_type = IMM_S;
            else if (is_br)            imm_type = IMM_B;
            else if (is_lui | is_auipc) imm_type = IMM_U;
            else if (is_jal)           imm_type = IMM_J;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_src_b = 1'b0;
        alu_src_a = SRCA_RS1;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        mdr_we    = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    retire  = 1'b1;
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_b = is_i | is_ld | is_st | is_jal | is_jalr | is_lui | is_auipc;
                if (is_lui)                alu_src_a = SRCA_ZERO;
                else if (is_auipc | is_jal) alu_src_a = SRCA_PC;
                if (is_ld | is_st) begin
                    state_d = S_MEM;
                end else if (is_br) begin
                    pc_we   = br_taken;
                    pc_sel  = PC_TARGET;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jal | is_jalr) begin
                    pc_we   = 1'b1;
                    pc_sel  = is_jal ? PC_TARGET : PC_ALU;
                    rf_we   = 1'b1;
                    wb_sel  = WB_PC4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_st;
                if (mem_ack) begin
                    if (is_st) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = is_ld ? WB_MEM : WB_ALU;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_BOOT;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // Sets on the same edge that enters TRAP, then sticks until reset.
    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table vectors, random instruction streams and reset/trap corner cases,
// all checked cycle by cycle against a per-instruction reference model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        br_taken = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, alu_src_b, rf_we, mdr_we, retire, illegal;
    logic [1:0]  pc_sel, alu_src_a, wb_sel;
    logic [2:0]  imm_type;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .br_taken(br_taken), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .alu_src_b(alu_src_b), .alu_src_a(alu_src_a), .imm_type(imm_type),
        .rf_we(rf_we), .wb_sel(wb_sel), .mdr_we(mdr_we), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
        logic [1:0] pc_sel;
        logic       alu_src_b;
        logic [1:0] alu_src_a;
        logic [2:0] imm_type;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       mdr_we, retire, illegal;
    } outs_t;

    outs_t act;
    assign act = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_src_b, alu_src_a,
                  imm_type, rf_we, wb_sel, mdr_we, retire, illegal};

    typedef struct {
        logic [31:0] inst;
        logic        ack;
        logic        br;
        outs_t       exp;
        int          len_exp;
    } step_t;

    typedef struct {
        logic [31:0] inst;
        logic        br;
        int          fw;
        int          mw;
        int          len;
    } vec_t;

    typedef enum {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_t;

    step_t       q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] ir_model = 32'h00112023;
    bit          trapped  = 1'b0;

    function automatic cls_t classify(input logic [31:0] i);
        case (i[6:0])
            7'h33:   return C_R;
            7'h13:   return C_I;
            7'h03:   return C_LD;
            7'h23:   return C_ST;
            7'h63:   return C_BR;
            7'h6F:   return C_JAL;
            7'h67:   return C_JALR;
            7'h37:   return C_LUI;
            7'h17:   return C_AUIPC;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] immt(input logic [31:0] i);
        case (classify(i))
            C_ST:          return 3'd1;
            C_BR:          return 3'd2;
            C_LUI, C_AUIPC: return 3'd3;
            C_JAL:         return 3'd4;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic outs_t idle();
        outs_t o;
        o          = '0;
        o.imm_type = immt(ir_model);
        o.illegal  = trapped;
        return o;
    endfunction

    function automatic logic rbit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    task automatic push(input logic ack, input logic br, input outs_t e, input int len);
        step_t s;
        s.inst = ir_model; s.ack = ack; s.br = br; s.exp = e; s.len_exp = len;
        q.push_back(s);
    endtask

    // Expands one instruction into its expected cycle-by-cycle strobe pattern.
    task automatic gen(input logic [31:0] i, input logic br, input int fw, input int mw, input int len);
        cls_t  c;
        outs_t e;
        int    l;
        c = classify(i);
        l = len;
        for (int k = 0; k <= fw; k++) begin
            e = idle();
            e.mem_req = 1'b1;
            if (k == fw) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
            push(k == fw, rbit(), e, l);
            l = 0;
        end
        ir_model = i;
        e = idle();
        if (c == C_ILL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            push(rbit(), rbit(), e, 0);
            trapped = 1'b1;
            for (int k = 0; k < 5; k++) push(rbit(), rbit(), idle(), 0);
`else
            e.retire = 1'b1;
            push(rbit(), rbit(), e, 0);
`endif
            return;
        end
        push(rbit(), rbit(), e, 0);
        e = idle();
        case (c)
            C_I, C_LD, C_ST, C_JALR: e.alu_src_b = 1'b1;
            C_LUI:          begin e.alu_src_a = 2'd2; e.alu_src_b = 1'b1; end
            C_AUIPC, C_JAL: begin e.alu_src_a = 2'd1; e.alu_src_b = 1'b1; end
            default: ;
        endcase
        if (c == C_BR) begin
            e.pc_we = br; e.pc_sel = 2'd1; e.retire = 1'b1;
        end else if (c == C_JAL || c == C_JALR) begin
            e.pc_we = 1'b1; e.pc_sel = (c == C_JAL) ? 2'd1 : 2'd2;
            e.rf_we = 1'b1; e.wb_sel = 2'd2; e.retire = 1'b1;
        end
        push(rbit(), br, e, 0);
        if (c == C_BR || c == C_JAL || c == C_JALR) return;
        if (c == C_LD || c == C_ST) begin
            for (int k = 0; k <= mw; k++) begin
                e = idle();
                e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (c == C_ST);
                if (k == mw) begin
                    if (c == C_ST) e.retire = 1'b1;
                    else           e.mdr_we = 1'b1;
                end
                push(k == mw, rbit(), e, 0);
            end
            if (c == C_ST) return;
        end
        e = idle();
        e.rf_we = 1'b1; e.wb_sel = (c == C_LD) ? 2'd1 : 2'd0; e.retire = 1'b1;
        push(rbit(), rbit(), e, 0);
    endtask

    task automatic check_outs(input string name, input outs_t e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s cyc=%0d inst=%h actual=%b required=%b", name, cyc, inst, act, e);
        end
    endtask

    task automatic run_queue(input string name);
        step_t s;
        int    start = 0;
        int    len   = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            inst = s.inst; mem_ack = s.ack; br_taken = s.br;
            #1;
            cyc++;
            if (s.len_exp != 0) begin start = cyc; len = s.len_exp; end
            check_outs(name, s.exp);
            if (act.retire && len != 0) begin
                n_tests++;
                if (cyc - start + 1 != len) begin
                    n_fail++;
                    $display("FAIL %s_latency inst=%h actual=%0d required=%0d", name, inst, cyc - start + 1, len);
                end
                len = 0;
            end
        end
    endtask

    // Assert reset on a falling edge and check the outputs collapse without waiting for a clock.
    task automatic reset_pulse(input string name);
        @(negedge clk);
        mem_ack = 1'b1; br_taken = 1'b1;
        rst_n = 1'b0;
        #1; check_outs({name, "_async"}, outs_t'(0));
        trapped = 1'b0;
        @(negedge clk); #1; check_outs({name, "_held"}, outs_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1; check_outs({name, "_boot"}, outs_t'(0));
    endtask

    vec_t        tbl[13];
    logic [6:0]  ops[9];
    logic [31:0] r;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'h00500093, 1'b0, 0, 0, 4};  // addi, zero wait
        tbl[1]  = '{32'h00500093, 1'b0, 0, 0, 4};
        tbl[2]  = '{32'h00500093, 1'b0, 3, 0, 7};  // fetch ack withheld 3 cycles
        tbl[3]  = '{32'h00112023, 1'b0, 0, 2, 6};  // sw, mem ack delayed 2
        tbl[4]  = '{32'h00208463, 1'b1, 0, 0, 3};  // beq taken
        tbl[5]  = '{32'h00208463, 1'b0, 0, 0, 3};  // beq not taken
        tbl[6]  = '{32'h0000A103, 1'b0, 0, 0, 5};  // lw
        tbl[7]  = '{32'h0000A103, 1'b0, 1, 1, 7};
        tbl[8]  = '{32'h004000EF, 1'b0, 0, 0, 3};  // jal
        tbl[9]  = '{32'h000080E7, 1'b0, 0, 0, 3};  // jalr
        tbl[10] = '{32'h123450B7, 1'b0, 0, 0, 4};  // lui
        tbl[11] = '{32'h00001097, 1'b0, 0, 0, 4};  // auipc
        tbl[12] = '{32'h002081B3, 1'b0, 0, 0, 4};  // add
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

        inst = ir_model; mem_ack = 1'b1; br_taken = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            check_outs("reset_quiet", outs_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1; check_outs("boot_after_release", outs_t'(0));

        foreach (tbl[k]) gen(tbl[k].inst, tbl[k].br, tbl[k].fw, tbl[k].mw, tbl[k].len);
        run_queue("table");

`ifndef CTRL_ILLEGAL_TRAP_EN
        gen(32'h0000000B, 1'b0, 0, 0, 2);
        gen(32'h00500090, 1'b0, 1, 0, 3);
        run_queue("illegal_nop");
`endif

        for (int n = 0; n < 120; n++) begin
            r = $urandom;
            if ($urandom_range(0, 4) != 0) r[6:0] = ops[$urandom_range(0, 8)];
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (classify(r) == C_ILL) r[6:0] = 7'h33;
`endif
            gen(r, rbit(), $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end
        run_queue("random");

        // Load interrupted by reset while waiting in MEM.
        gen(32'h0000A103, 1'b0, 0, 3, 0);
        repeat (3) void'(q.pop_back());
        run_queue("load_pre_reset");
        reset_pulse("reset_mid_mem");
        gen(32'h00500093, 1'b0, 0, 0, 4);
        run_queue("restart_after_reset");

`ifdef CTRL_ILLEGAL_TRAP_EN
        gen(32'h0000000B, 1'b0, 0, 0, 0);
        run_queue("trap");
        reset_pulse("trap_reset");
        gen(32'h00500093, 1'b0, 0, 0, 4);
        run_queue("restart_after_trap");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
